// File: rtl/morse_key_controller.sv
// Debounces a raw telegraph key and classifies presses/gaps into Dot, Dash, EndSeq, Space strobes.
// Strobes are registered, DebounceCycles+1 after the raw edge; no backpressure, downstream must accept every strobe.
module morse_key_controller #(
   parameter int UnitCycles     = 8,
   parameter int DebounceCycles = 4,
   parameter int MaxSymbols     = 5
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       KeyIn,
   input  logic       ClearReq,
   output logic       Dot,
   output logic       Dash,
   output logic       EndSeq,
   output logic       Space,
   output logic       Clear,
   output logic [2:0] SymCount,
   output logic       Overflow,
   output logic       Idle
);

   localparam int CntMax = 7 * UnitCycles;
   localparam int CntW   = $clog2(CntMax + 1);
   localparam int DbW    = $clog2(DebounceCycles + 1);

   localparam logic [CntW-1:0] DotLimit  = CntW'(2 * UnitCycles);
   localparam logic [CntW-1:0] LetterGap = CntW'(3 * UnitCycles);
   localparam logic [CntW-1:0] WordGap   = CntW'(CntMax);
   localparam logic [CntW-1:0] SpaceAt   = CntW'(CntMax - 1);
   localparam logic [DbW-1:0]  DbLast    = DbW'(DebounceCycles - 1);
   localparam logic [2:0]      SymLimit  = 3'(MaxSymbols);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PRESS   = 2'd1;
   localparam logic [1:0] GAP     = 2'd2;
   localparam logic [1:0] DISCARD = 2'd3;

   logic            keyClean;
   logic [DbW-1:0]  runCnt;
   logic [1:0]      state;
   logic [CntW-1:0] lenCnt;
   logic [CntW-1:0] gapCnt;

   // Any sample equal to the current clean level restarts the run.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         keyClean <= 1'b0;
         runCnt   <= '0;
      end else if (KeyIn == keyClean) begin
         runCnt <= '0;
      end else if (runCnt == DbLast) begin
         keyClean <= KeyIn;
         runCnt   <= '0;
      end else begin
         runCnt <= runCnt + DbW'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         lenCnt   <= '0;
         gapCnt   <= '0;
         SymCount <= 3'd0;
         Overflow <= 1'b0;
         Dot      <= 1'b0;
         Dash     <= 1'b0;
         EndSeq   <= 1'b0;
         Space    <= 1'b0;
         Clear    <= 1'b0;
      end else begin
         Dot    <= 1'b0;
         Dash   <= 1'b0;
         EndSeq <= 1'b0;
         Space  <= 1'b0;
         Clear  <= ClearReq;
         if (ClearReq) begin
            SymCount <= 3'd0;
            Overflow <= 1'b0;
            lenCnt   <= '0;
            gapCnt   <= '0;
            state    <= keyClean ? DISCARD : IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (keyClean) begin
                     state  <= PRESS;
                     lenCnt <= CntW'(1);
                  end
               end
               PRESS: begin
                  if (keyClean) begin
                     if (lenCnt != WordGap) lenCnt <= lenCnt + CntW'(1);
                  end else begin
                     // A full sequence swallows the press but remembers it happened.
                     if (SymCount == SymLimit) begin
                        Overflow <= 1'b1;
                     end else begin
                        Dot      <= (lenCnt < DotLimit);
                        Dash     <= (lenCnt >= DotLimit);
                        SymCount <= SymCount + 3'd1;
                     end
                     state  <= GAP;
                     gapCnt <= CntW'(1);
                     lenCnt <= '0;
                  end
               end
               GAP: begin
                  if (keyClean) begin
                     if (gapCnt >= LetterGap) begin
                        EndSeq   <= (SymCount != 3'd0);
                        SymCount <= 3'd0;
                     end
                     state  <= PRESS;
                     lenCnt <= CntW'(1);
                     gapCnt <= '0;
                  end else if (gapCnt >= SpaceAt) begin
                     Space    <= (SymCount != 3'd0);
                     SymCount <= 3'd0;
                     gapCnt   <= WordGap;
                     state    <= IDLE;
                  end else begin
                     gapCnt <= gapCnt + CntW'(1);
                  end
               end
               DISCARD: begin
                  if (!keyClean) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign Idle = (state == IDLE);

endmodule

// File: tb/tb_morse_key_controller.sv
// Bench for morse_key_controller: directed plan plus random key traffic, checked against an
// edge-timestamp reference model through a strobe scoreboard.
module tb_morse_key_controller;

   localparam int U      = 8;
   localparam int D      = 4;
   localparam int MaxSym = 5;

   logic       Clk = 1'b0;
   logic       Reset, KeyIn, ClearReq;
   logic       Dot, Dash, EndSeq, Space, Clear, Overflow, Idle;
   logic [2:0] SymCount;

   morse_key_controller #(.UnitCycles(U), .DebounceCycles(D), .MaxSymbols(MaxSym)) dut (
      .Clk(Clk), .Reset(Reset), .KeyIn(KeyIn), .ClearReq(ClearReq),
      .Dot(Dot), .Dash(Dash), .EndSeq(EndSeq), .Space(Space), .Clear(Clear),
      .SymCount(SymCount), .Overflow(Overflow), .Idle(Idle)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int nDot = 0, nDash = 0, nEnd = 0, nSpace = 0, nClear = 0;
   int lastDot = -1, lastDash = -1, lastEnd = -1, lastSpace = -1;
   int sDot, sDash, sEnd, sSpace, sClear;

   // kind bits: 0 Dot, 1 Dash, 2 EndSeq, 3 Space, 4 Clear
   typedef struct { int cyc; logic [4:0] kind; int sym; bit ovf; } exp_t;
   exp_t expQ[$];

   bit clean, pressing, gapping, discarding, mOvf;
   int mSym, pressEdge, relEdge, ones;
   bit hist[$];

   task automatic check(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic pushExp(input logic [4:0] kind);
      exp_t e;
      e.cyc = cyc; e.kind = kind; e.sym = mSym; e.ovf = mOvf;
      expQ.push_back(e);
   endtask

   // Reference model: works on timestamps of clean edges rather than running counters.
   initial begin
      forever begin
         @(posedge Clk);
         cyc++;
         if (Reset) begin
            clean = 0; hist.delete();
            pressing = 0; gapping = 0; discarding = 0; mSym = 0; mOvf = 0;
         end else begin
            if (ClearReq) begin
               mSym = 0; mOvf = 0; pressing = 0; gapping = 0; discarding = clean;
               pushExp(5'b10000);
            end else if (pressing) begin
               if (!clean) begin
                  pressing = 0; gapping = 1; relEdge = cyc;
                  if (mSym == MaxSym) mOvf = 1;
                  else begin
                     mSym++;
                     pushExp((cyc - pressEdge < 2 * U) ? 5'b00001 : 5'b00010);
                  end
               end
            end else if (gapping) begin
               if (clean) begin
                  if (cyc - relEdge >= 3 * U && mSym > 0) begin
                     mSym = 0; pushExp(5'b00100);
                  end else if (cyc - relEdge >= 3 * U) mSym = 0;
                  gapping = 0; pressing = 1; pressEdge = cyc;
               end else if (cyc - relEdge + 1 >= 7 * U) begin
                  gapping = 0;
                  if (mSym > 0) begin mSym = 0; pushExp(5'b01000); end
               end
            end else if (discarding) begin
               if (!clean) discarding = 0;
            end else if (clean) begin
               pressing = 1; pressEdge = cyc;
            end
            hist.push_back(KeyIn);
            if (hist.size() > D) hist = hist[1:$];
            ones = 0;
            foreach (hist[i]) if (hist[i]) ones++;
            if (hist.size() == D && ones == D) clean = 1;
            else if (hist.size() == D && ones == 0) clean = 0;
         end
      end
   end

   // Monitor: pops the scoreboard whenever any strobe is presented.
   initial begin
      logic [4:0] strobes;
      exp_t e;
      forever begin
         @(negedge Clk);
         strobes = {Clear, Space, EndSeq, Dash, Dot};
         while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            check(1'b0, "missed strobe", 0, int'(expQ[0].kind));
            e = expQ.pop_front();
         end
         if (strobes != 5'b0) begin
            if (Dot)    begin nDot++;   lastDot   = cyc; end
            if (Dash)   begin nDash++;  lastDash  = cyc; end
            if (EndSeq) begin nEnd++;   lastEnd   = cyc; end
            if (Space)  begin nSpace++; lastSpace = cyc; end
            if (Clear)  nClear++;
            if (expQ.size() == 0 || expQ[0].cyc != cyc) begin
               check(1'b0, "unexpected strobe", int'(strobes), 0);
            end else begin
               e = expQ.pop_front();
               check(strobes == e.kind, "strobe kind", int'(strobes), int'(e.kind));
               check(int'(SymCount) == e.sym, "strobe SymCount", int'(SymCount), e.sym);
               check(Overflow == e.ovf, "strobe Overflow", int'(Overflow), int'(e.ovf));
            end
         end
         check(int'(SymCount) == mSym, "SymCount", int'(SymCount), mSym);
         check(Overflow == mOvf, "Overflow", int'(Overflow), int'(mOvf));
         check(Idle == !(pressing || gapping || discarding), "Idle", int'(Idle),
               int'(!(pressing || gapping || discarding)));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic press(input int n);
      KeyIn = 1'b1; step(n); KeyIn = 1'b0;
   endtask

   task automatic gap(input int n);
      KeyIn = 1'b0; step(n);
   endtask

   task automatic snap();
      sDot = nDot; sDash = nDash; sEnd = nEnd; sSpace = nSpace; sClear = nClear;
   endtask

   initial begin
      int rel, pst, r;
      Reset = 1'b1; KeyIn = 1'b0; ClearReq = 1'b0;
      step(3);
      check({Dot, Dash, EndSeq, Space, Clear} == 5'b0, "reset strobes", int'({Dot, Dash, EndSeq, Space, Clear}), 0);
      check(SymCount == 3'd0 && Overflow == 1'b0, "reset count", int'(SymCount), 0);
      check(Idle == 1'b1, "reset Idle", int'(Idle), 1);
      Reset = 1'b0;
      step(5);

      // Dot/Dash threshold at 2U
      snap();
      press(15); rel = cyc; gap(10);
      press(16); pst = cyc; gap(10);
      check(lastDot == rel + 5, "dot latency", lastDot, rel + 5);
      check(lastDash == pst + 5, "dash latency", lastDash, pst + 5);
      check(nDot - sDot == 1 && nDash - sDash == 1, "threshold strobes", nDot - sDot, 1);
      check(SymCount == 3'd2, "threshold SymCount", int'(SymCount), 2);
      check(nEnd == sEnd, "threshold no EndSeq", nEnd - sEnd, 0);
      gap(70);

      // Letter gap
      press(8); gap(10); press(24); gap(10); press(8); gap(10); press(8); gap(10); press(24);
      gap(30);
      check(SymCount == 3'd5, "letter SymCount before", int'(SymCount), 5);
      pst = cyc;
      press(8); gap(10);
      check(lastEnd == pst + 5, "endseq latency", lastEnd, pst + 5);
      check(SymCount == 3'd1, "letter SymCount after", int'(SymCount), 1);
      gap(70);

      // Word gap
      snap();
      press(8); gap(10); press(8); gap(10); press(8); rel = cyc;
      gap(70);
      check(nSpace - sSpace == 1, "word Space count", nSpace - sSpace, 1);
      check(lastSpace == rel + 60, "space latency", lastSpace, rel + 60);
      check(Idle == 1'b1, "word Idle", int'(Idle), 1);
      gap(20);
      check(nSpace - sSpace == 1, "word no extra Space", nSpace - sSpace, 1);

      // Overflow
      snap();
      for (int i = 0; i < 6; i++) begin press(8); gap(10); end
      check(nDot - sDot == 5, "overflow dots", nDot - sDot, 5);
      check(Overflow == 1'b1 && SymCount == 3'd5, "overflow set", int'(Overflow), 1);
      gap(70);
      check(nSpace - sSpace == 1, "overflow Space", nSpace - sSpace, 1);
      check(Overflow == 1'b1, "overflow sticky", int'(Overflow), 1);
      ClearReq = 1'b1; step(1); ClearReq = 1'b0;
      check(Clear == 1'b1 && Overflow == 1'b0, "clear drops Overflow", int'(Overflow), 0);
      step(1);

      // Clear mid-press
      snap();
      press(8); gap(10);
      KeyIn = 1'b1; step(10);
      ClearReq = 1'b1; step(1); ClearReq = 1'b0;
      check(Clear == 1'b1 && SymCount == 3'd0, "clear mid-press", int'(SymCount), 0);
      step(9); gap(20);
      check(nDash == sDash, "no dash after clear", nDash - sDash, 0);
      check(Idle == 1'b1 && nClear - sClear == 1, "clear back to idle", nClear - sClear, 1);
      snap();
      ClearReq = 1'b1; step(3); ClearReq = 1'b0; step(2);
      check(nClear - sClear == 3, "held clear count", nClear - sClear, 3);

      // Bounce then reset during a press
      snap();
      for (int i = 0; i < 5; i++) begin KeyIn = 1'b1; step(2); KeyIn = 1'b0; step(2); end
      gap(10);
      check(nDot + nDash + nEnd + nSpace == sDot + sDash + sEnd + sSpace, "bounce no strobe",
            nDot + nDash + nEnd + nSpace - sDot - sDash - sEnd - sSpace, 0);
      press(8); gap(10);
      snap();
      KeyIn = 1'b1; step(5);
      Reset = 1'b1; step(1);
      check({Dot, Dash, EndSeq, Space, Clear} == 5'b0 && SymCount == 3'd0 && Overflow == 1'b0,
            "reset mid-press outputs", int'(SymCount), 0);
      check(Idle == 1'b1, "reset mid-press Idle", int'(Idle), 1);
      step(1); Reset = 1'b0;
      step(5); gap(20);
      check(nDot - sDot == 1 && nClear == sClear, "press re-measured after reset", nDot - sDot, 1);
      gap(70);

      // Random traffic
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            KeyIn = 1'b1; step($urandom_range(3, 15));
            ClearReq = 1'b1; step($urandom_range(1, 2)); ClearReq = 1'b0;
            step($urandom_range(0, 10));
         end else if (r == 1) begin
            press($urandom_range(1, 3));
         end else begin
            press($urandom_range(4, 40));
         end
         gap($urandom_range(2, 70));
      end
      gap(80);
      check(expQ.size() == 0, "pending expected strobes", expQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
